// File: rtl/apb_master_sched_pkg.sv
// Shared types and width helpers for the APB master scheduler.
package apb_master_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  // Width of an index into n items; never returns zero so vectors stay legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int slv_idx_w(input int num_slv);
    return idx_w(num_slv);
  endfunction

  // Counter must be able to hold the value TIMEOUT itself.
  function automatic int timeout_w(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_master_sched_rr_arbiter.sv
// Round-robin arbiter: priority starts one past the last granted requester.
module rr_arbiter
  import apb_master_sched_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr_reg;
  logic          found;
  int            cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr_reg) + k) % N;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
  end

  // Pointer moves only when the grant is actually taken by the scheduler.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (advance && found) begin
      ptr_reg <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/apb_master_sched.sv
// Shares one APB master port between NUM_REQ requesters with round-robin
// arbitration, one transfer in flight, slave decode and a wait-state timeout.
module apb_master_sched
  import apb_master_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_SLV     = 16,
  parameter int SLV_SEL_LSB = 12,
  parameter int TIMEOUT     = 256
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  output logic                      PWRITE,
  output logic [NUM_SLV-1:0]        PSEL,
  output logic                      PENABLE,
  input  logic [DATA_W-1:0]         PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam int SLV_IDX_W = slv_idx_w(NUM_SLV);
  localparam int TIMEOUT_W = timeout_w(TIMEOUT);
  localparam int REQ_IDX_W = idx_w(NUM_REQ);
  localparam logic [TIMEOUT_W-1:0] TMO_LAST =
    (TIMEOUT > 0) ? TIMEOUT_W'(TIMEOUT - 1) : '0;

  state_e                 state_reg, state_next;
  logic [NUM_REQ-1:0]     grant;
  logic [REQ_IDX_W-1:0]   grant_idx;
  logic [REQ_IDX_W-1:0]   winner_reg;
  logic [TIMEOUT_W-1:0]   tmo_cnt_reg;
  logic [ADDR_W-1:0]      addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]      wdata_arr [NUM_REQ];
  logic [ADDR_W-1:0]      sel_addr;
  logic [SLV_IDX_W-1:0]   sel_slv;
  logic [NUM_SLV-1:0]     sel_psel;
  logic                   any_req;
  logic                   accept;
  logic                   access_done;
  logic                   access_abort;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .clk       (PCLK),
    .rst       (PRESET),
    .req       (req_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign any_req  = |req_valid;
  assign sel_addr = addr_arr[grant_idx];
  assign sel_slv  = sel_addr[SLV_SEL_LSB +: SLV_IDX_W];
  assign sel_psel = {{(NUM_SLV-1){1'b0}}, 1'b1} << sel_slv;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // PREADY wins over the timeout when both would end the same ACCESS cycle.
  always_comb begin
    state_next   = state_reg;
    access_done  = 1'b0;
    access_abort = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (any_req) state_next = SETUP;
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          access_done = 1'b1;
          state_next  = any_req ? SETUP : IDLE;
        end else if ((TIMEOUT != 0) && (tmo_cnt_reg == TMO_LAST)) begin
          access_abort = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The accept window is IDLE or the completing ACCESS cycle (back-to-back).
  assign accept    = any_req && !PRESET && ((state_reg == IDLE) || access_done);
  assign req_ready = accept ? grant : '0;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PADDR       <= '0;
      PWDATA      <= '0;
      PWRITE      <= 1'b0;
      PSEL        <= '0;
      PENABLE     <= 1'b0;
      winner_reg  <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      tmo_cnt_reg <= '0;
    end else begin
      rsp_valid <= '0;

      if (accept) begin
        PADDR      <= sel_addr;
        PWDATA     <= wdata_arr[grant_idx];
        PWRITE     <= req_write[grant_idx];
        PSEL       <= sel_psel;
        PENABLE    <= 1'b0;
        winner_reg <= grant_idx;
      end else if (state_reg == SETUP) begin
        PENABLE <= 1'b1;
      end else if (access_done || access_abort) begin
        PSEL    <= '0;
        PENABLE <= 1'b0;
      end

      if (access_done) begin
        rsp_valid   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_reg;
        rsp_rdata   <= PWRITE ? '0 : PRDATA;
        rsp_err     <= PSLVERR;
        rsp_timeout <= 1'b0;
      end else if (access_abort) begin
        rsp_valid   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_reg;
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end

      if (state_reg == SETUP) begin
        tmo_cnt_reg <= '0;
      end else if ((state_reg == ACCESS) && !PREADY && (TIMEOUT != 0)) begin
        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_sched.sv
// Directed and randomized checks of the APB scheduler against a transaction-level model.
module tb_apb_master_sched;

  localparam int NR  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NS  = 16;
  localparam int LSB = 12;
  localparam int SW  = $clog2(NS);
  localparam int TMO = 8;

  logic             PCLK = 1'b0;
  logic             PRESET = 1'b1;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_write = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err;
  logic             rsp_timeout;
  logic [AW-1:0]    PADDR;
  logic [DW-1:0]    PWDATA;
  logic             PWRITE;
  logic [NS-1:0]    PSEL;
  logic             PENABLE;
  logic [DW-1:0]    PRDATA = '0;
  logic             PREADY = 1'b0;
  logic             PSLVERR = 1'b0;

  apb_master_sched #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS),
    .SLV_SEL_LSB(LSB), .TIMEOUT(TMO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Requester-side model state
  bit          pending  [NR];
  bit          r_write  [NR];
  logic [31:0] r_addr   [NR];
  logic [31:0] r_wdata  [NR];
  logic [31:0] r_prdata [NR];
  bit          r_slverr [NR];
  int          r_waits  [NR];
  int          ptr      = 0;
  bit          wait_err = 0;

  bit          rsp_due = 0;
  logic [63:0] e_valid, e_rdata;
  bit          e_err, e_to;

  function automatic logic [63:0] bit1(input int i);
    return 64'd1 << i;
  endfunction

  function automatic int slv_of(input logic [31:0] a);
    return int'(a[LSB +: SW]);
  endfunction

  // Round-robin rule: first pending requester at or after the pointer.
  function automatic int pick();
    for (int k = 0; k < NR; k++)
      if (pending[(ptr + k) % NR]) return (ptr + k) % NR;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]             = pending[i];
      req_write[i]             = r_write[i];
      req_addr[i*AW +: AW]     = r_addr[i];
      req_wdata[i*DW +: DW]    = r_wdata[i];
    end
  endtask

  task automatic set_req(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input int waits, input logic [31:0] rd, input bit serr);
    pending[i]  = 1'b1;
    r_write[i]  = wr;
    r_addr[i]   = a;
    r_wdata[i]  = d;
    r_waits[i]  = waits;
    r_prdata[i] = rd;
    r_slverr[i] = serr;
  endtask

  task automatic chk_rsp();
    if (rsp_due) begin
      chk("rsp_valid", 64'(rsp_valid), e_valid);
      chk("rsp_rdata", 64'(rsp_rdata), e_rdata);
      chk("rsp_err", 64'(rsp_err), 64'(e_err));
      chk("rsp_timeout", 64'(rsp_timeout), 64'(e_to));
      rsp_due = 0;
    end else begin
      chk("rsp_quiet", 64'(rsp_valid), 64'd0);
    end
  endtask

  // Entered just after the inputs were driven in a cycle where the DUT is IDLE.
  task automatic run_batch();
    int  w, nw, nlow;
    bit  timed;
    w = pick();
    @(negedge PCLK);
    chk("ready_first", 64'(req_ready), (w >= 0) ? bit1(w) : 64'd0);
    while (w >= 0) begin
      pending[w] = 0;
      ptr = (w + 1) % NR;
      @(posedge PCLK); #1;
      drive_reqs();
      PREADY = 1'b0; PSLVERR = 1'b0;
      @(negedge PCLK);
      chk_rsp();
      chk("setup_psel", 64'(PSEL), bit1(slv_of(r_addr[w])));
      chk("setup_penable", 64'(PENABLE), 64'd0);
      chk("setup_paddr", 64'(PADDR), 64'(r_addr[w]));
      chk("setup_pwrite", 64'(PWRITE), 64'(r_write[w]));
      if (r_write[w]) chk("setup_pwdata", 64'(PWDATA), 64'(r_wdata[w]));
      timed = (r_waits[w] >= TMO);
      nlow  = timed ? TMO : r_waits[w];
      for (int k = 0; k < nlow; k++) begin
        @(posedge PCLK); #1;
        PREADY  = 1'b0;
        PSLVERR = wait_err | 1'($urandom_range(0, 1));
        PRDATA  = $urandom;
        @(negedge PCLK);
        chk("wait_penable", 64'(PENABLE), 64'd1);
        chk("wait_psel", 64'(PSEL), bit1(slv_of(r_addr[w])));
        chk("wait_no_ready", 64'(req_ready), 64'd0);
      end
      if (!timed) begin
        @(posedge PCLK); #1;
        PREADY = 1'b1; PRDATA = r_prdata[w]; PSLVERR = r_slverr[w];
        nw = pick();
        @(negedge PCLK);
        chk("exit_penable", 64'(PENABLE), 64'd1);
        chk("b2b_ready", 64'(req_ready), (nw >= 0) ? bit1(nw) : 64'd0);
        rsp_due = 1;
        e_valid = bit1(w);
        e_rdata = r_write[w] ? 64'd0 : 64'(r_prdata[w]);
        e_err   = r_slverr[w];
        e_to    = 0;
      end else begin
        @(posedge PCLK); #1;
        PREADY = 1'b0; PSLVERR = 1'b0;
        nw = pick();
        rsp_due = 1;
        e_valid = bit1(w);
        e_rdata = 64'd0;
        e_err   = 1;
        e_to    = 1;
        @(negedge PCLK);
        chk_rsp();
        chk("abort_psel", 64'(PSEL), 64'd0);
        chk("abort_penable", 64'(PENABLE), 64'd0);
        chk("abort_ready", 64'(req_ready), (nw >= 0) ? bit1(nw) : 64'd0);
      end
      w = nw;
    end
    @(posedge PCLK); #1;
    PREADY = 1'b0; PSLVERR = 1'b0;
    @(negedge PCLK);
    chk_rsp();
    chk("idle_psel", 64'(PSEL), 64'd0);
    chk("idle_penable", 64'(PENABLE), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      pending[i] = 0; r_write[i] = 0; r_addr[i] = '0; r_wdata[i] = '0;
      r_prdata[i] = '0; r_slverr[i] = 0; r_waits[i] = 0;
    end

    // Reset values
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;
    @(negedge PCLK);
    chk("rst_psel", 64'(PSEL), 64'd0);
    chk("rst_penable", 64'(PENABLE), 64'd0);
    chk("rst_pwrite", 64'(PWRITE), 64'd0);
    chk("rst_paddr", 64'(PADDR), 64'd0);
    chk("rst_pwdata", 64'(PWDATA), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);

    // Zero-wait write from requester 0
    @(posedge PCLK); #1;
    set_req(0, 1, 32'h0000_100C, 32'h0000_00A5, 0, 32'h0, 0);
    drive_reqs(); run_batch();

    // Read with three wait states from requester 2
    @(posedge PCLK); #1;
    set_req(2, 0, 32'h0000_3000, 32'h0, 3, 32'h0000_1234, 0);
    drive_reqs(); run_batch();

    // Bring the pointer back to 0
    @(posedge PCLK); #1;
    set_req(3, 1, 32'h0000_3004, 32'h5A5A_0003, 0, 32'h0, 0);
    drive_reqs(); run_batch();

    // All four at once, twice: order 0,1,2,3 back-to-back each round
    for (int rnd = 0; rnd < 2; rnd++) begin
      @(posedge PCLK); #1;
      set_req(0, 1, 32'h0000_1000, 32'h1111_0000, 0, 32'h0, 0);
      set_req(1, 0, 32'h0000_1010, 32'h0, 1, 32'hBEEF_0001, 0);
      set_req(2, 1, 32'h0000_2000, 32'h2222_0000, 0, 32'h0, 0);
      set_req(3, 0, 32'h0000_2008, 32'h0, 2, 32'hCAFE_0003, 0);
      drive_reqs(); run_batch();
    end

    // Timeout on requester 1, requester 2 then proceeds normally
    @(posedge PCLK); #1;
    set_req(1, 0, 32'h0000_7000, 32'h0, 20, 32'hDEAD_DEAD, 0);
    set_req(2, 0, 32'h0000_8004, 32'h0, 1, 32'h0000_7777, 0);
    drive_reqs(); run_batch();

    // PSLVERR only counts when sampled with PREADY
    wait_err = 1;
    @(posedge PCLK); #1;
    set_req(0, 0, 32'h0000_9000, 32'h0, 2, 32'h0000_0A0A, 0);
    set_req(3, 0, 32'h0000_A000, 32'h0, 1, 32'h0000_0B0B, 1);
    drive_reqs(); run_batch();
    wait_err = 0;

    // Reset during ACCESS
    @(posedge PCLK); #1;
    set_req(2, 0, 32'h0000_5000, 32'h0, 0, 32'h0, 0);
    drive_reqs();
    @(negedge PCLK);
    chk("mid_accept", 64'(req_ready), 64'h4);
    pending[2] = 0; ptr = 3;
    @(posedge PCLK); #1;
    set_req(1, 1, 32'h0000_6000, 32'h0000_0061, 0, 32'h0, 0);
    set_req(3, 1, 32'h0000_6100, 32'h0000_0063, 0, 32'h0, 0);
    drive_reqs();
    @(negedge PCLK);
    chk("mid_setup_psel", 64'(PSEL), 64'h20);
    @(posedge PCLK); #1;
    PREADY = 1'b0;
    @(negedge PCLK);
    chk("mid_access_penable", 64'(PENABLE), 64'd1);
    #2 PRESET = 1'b1;
    #1;
    chk("async_psel", 64'(PSEL), 64'd0);
    chk("async_penable", 64'(PENABLE), 64'd0);
    repeat (2) begin
      @(negedge PCLK);
      chk("in_rst_rsp", 64'(rsp_valid), 64'd0);
      chk("in_rst_ready", 64'(req_ready), 64'd0);
    end
    @(posedge PCLK); #1;
    PRESET = 1'b0; ptr = 0; rsp_due = 0;
    run_batch();

    // Randomized traffic
    for (int b = 0; b < 25; b++) begin
      @(posedge PCLK); #1;
      begin
        logic [3:0] mask;
        mask = 4'($urandom_range(1, 15));
        for (int i = 0; i < NR; i++) begin
          if (mask[i])
            set_req(i, 1'($urandom), $urandom, $urandom,
                    ($urandom_range(0, 9) == 0) ? 9 : int'($urandom_range(0, 3)),
                    $urandom, 1'($urandom));
        end
      end
      drive_reqs(); run_batch();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
